// File: rtl/vtc_640x480.sv
// rtl/vtc_640x480.sv - 640x480@60 video timing controller: X/Y counters with registered hsync/vsync/active
module vtc_640x480 #(
  parameter int COUNTER_WIDTH = 10,
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter bit SYNC_ACTIVE   = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  output logic                     o_hsync,
  output logic                     o_vsync,
  output logic                     o_active,
  output logic [COUNTER_WIDTH-1:0] o_counterX,
  output logic [COUNTER_WIDTH-1:0] o_counterY
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Every boundary is pre-sized to the counter width so compares never mix widths.
  localparam logic [COUNTER_WIDTH-1:0] C_ONE      = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] C_H_LAST   = COUNTER_WIDTH'(H_TOTAL - 1);
  localparam logic [COUNTER_WIDTH-1:0] C_V_LAST   = COUNTER_WIDTH'(V_TOTAL - 1);
  localparam logic [COUNTER_WIDTH-1:0] C_H_ACTIVE = COUNTER_WIDTH'(H_ACTIVE);
  localparam logic [COUNTER_WIDTH-1:0] C_V_ACTIVE = COUNTER_WIDTH'(V_ACTIVE);
  localparam logic [COUNTER_WIDTH-1:0] C_HS_START = COUNTER_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [COUNTER_WIDTH-1:0] C_HS_END   = COUNTER_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COUNTER_WIDTH-1:0] C_VS_START = COUNTER_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [COUNTER_WIDTH-1:0] C_VS_END   = COUNTER_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

  logic [COUNTER_WIDTH-1:0] r_x;
  logic [COUNTER_WIDTH-1:0] r_y;
  logic                     r_hsync;
  logic                     r_vsync;
  logic                     r_active;

  logic                     w_x_wrap;
  logic                     w_y_wrap;
  logic [COUNTER_WIDTH-1:0] w_x_next;
  logic [COUNTER_WIDTH-1:0] w_y_next;
  logic                     w_active_next;
  logic                     w_hs_in_pulse;
  logic                     w_vs_in_pulse;

  // Next raster position: X wraps every line, Y steps only when X wraps, both wrap at end of frame.
  always_comb begin
    w_x_wrap = (r_x == C_H_LAST);
    w_y_wrap = (r_y == C_V_LAST);
    w_x_next = w_x_wrap ? '0 : (r_x + C_ONE);
    if (w_x_wrap) begin
      w_y_next = w_y_wrap ? '0 : (r_y + C_ONE);
    end else begin
      w_y_next = r_y;
    end
  end

  // Flags are decoded from the next position so the registered flags line up with the registered counters.
  always_comb begin
    w_active_next = (w_x_next < C_H_ACTIVE) && (w_y_next < C_V_ACTIVE);
    w_hs_in_pulse = (w_x_next >= C_HS_START) && (w_x_next < C_HS_END);
    w_vs_in_pulse = (w_y_next >= C_VS_START) && (w_y_next < C_VS_END);
  end

  // Raster counters; reset parks the beam at pixel (0,0).
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      r_x <= w_x_next;
      r_y <= w_y_next;
    end
  end

  // Registered flags; reset values are the decode of pixel (0,0).
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_active <= 1'b1;
      r_hsync  <= ~SYNC_ACTIVE;
      r_vsync  <= ~SYNC_ACTIVE;
    end else begin
      r_active <= w_active_next;
      r_hsync  <= w_hs_in_pulse ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_vsync  <= w_vs_in_pulse ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end

  assign o_counterX = r_x;
  assign o_counterY = r_y;
  assign o_active   = r_active;
  assign o_hsync    = r_hsync;
  assign o_vsync    = r_vsync;

endmodule

// File: tb/tb_vtc_640x480.sv
// tb/tb_vtc_640x480.sv - scoreboard bench for vtc_640x480 at full and reduced geometry
module tb_vtc_640x480;

  // Reduced geometry instance lets whole frames, vsync and frame wrap be observed in a short run.
  localparam int B_HA = 12, B_HF = 2, B_HS = 3, B_HB = 3;
  localparam int B_VA = 6,  B_VF = 2, B_VS = 2, B_VB = 3;
  localparam int B_HT = B_HA + B_HF + B_HS + B_HB;
  localparam int B_VT = B_VA + B_VF + B_VS + B_VB;
  localparam int N_CYCLES = 50000;

  typedef struct {
    int dut;
    int t;
    int x;
    int y;
    bit act;
    bit hs;
    bit vs;
  } exp_t;

  exp_t q[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn_a, rstn_b;
  logic       hs_a, vs_a, act_a;
  logic       hs_b, vs_b, act_b;
  logic [9:0] cx_a, cy_a;
  logic [4:0] cx_b, cy_b;

  int vectors = 0;
  int miscompares = 0;

  vtc_640x480 u_dut_a (
    .i_clk      (clk),
    .i_rstn     (rstn_a),
    .o_hsync    (hs_a),
    .o_vsync    (vs_a),
    .o_active   (act_a),
    .o_counterX (cx_a),
    .o_counterY (cy_a)
  );

  vtc_640x480 #(
    .COUNTER_WIDTH (5),
    .H_ACTIVE (B_HA), .H_FP (B_HF), .H_SYNC (B_HS), .H_BP (B_HB),
    .V_ACTIVE (B_VA), .V_FP (B_VF), .V_SYNC (B_VS), .V_BP (B_VB),
    .SYNC_ACTIVE (1'b0)
  ) u_dut_b (
    .i_clk      (clk),
    .i_rstn     (rstn_b),
    .o_hsync    (hs_b),
    .o_vsync    (vs_b),
    .o_active   (act_b),
    .o_counterX (cx_b),
    .o_counterY (cy_b)
  );

  // Reference: t is the number of clock edges since reset release; position and flags follow by arithmetic.
  function automatic exp_t model(int d, int t);
    exp_t e;
    int ha, hf, hs, hb, va, vf, vs, vb, ht, vt;
    bit sa;
    if (d == 0) begin
      ha = 640; hf = 16; hs = 96; hb = 48; va = 480; vf = 10; vs = 2; vb = 33; sa = 1'b1;
    end else begin
      ha = B_HA; hf = B_HF; hs = B_HS; hb = B_HB; va = B_VA; vf = B_VF; vs = B_VS; vb = B_VB; sa = 1'b0;
    end
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    e.dut = d;
    e.t   = t;
    e.x   = t % ht;
    e.y   = (t / ht) % vt;
    e.act = (e.x < ha) && (e.y < va);
    e.hs  = (e.x >= ha + hf && e.x < ha + hf + hs) ? sa : !sa;
    e.vs  = (e.y >= va + vf && e.y < va + vf + vs) ? sa : !sa;
    return e;
  endfunction

  // Stimulus: random reset pulses (asserted away from the clock edge), a directed mid-frame reset per DUT.
  int  t_a, t_b, hold_a, hold_b;
  bit  done_a, done_b;
  initial begin
    rstn_a = 1'b0; rstn_b = 1'b0;
    t_a = 0; t_b = 0;
    hold_a = 2; hold_b = 3;
    done_a = 1'b0; done_b = 1'b0;
    for (int i = 0; i < N_CYCLES; i++) begin
      @(posedge clk);
      if (rstn_a) t_a++;
      if (rstn_b) t_b++;
      #2;
      if (!rstn_a) begin
        if (hold_a == 0) rstn_a = 1'b1;
        else hold_a--;
      end else if ((!done_a && t_a == 20 * 800 + 300) ||
                   (done_a && $urandom_range(0, 39999) == 0)) begin
        done_a = 1'b1;
        rstn_a = 1'b0;
        t_a    = 0;
        hold_a = $urandom_range(0, 3);
      end
      if (!rstn_b) begin
        if (hold_b == 0) rstn_b = 1'b1;
        else hold_b--;
      end else if ((!done_b && i > 1000 && t_b == 4 * B_HT + 7) ||
                   ($urandom_range(0, 1999) == 0)) begin
        done_b = 1'b1;
        rstn_b = 1'b0;
        t_b    = 0;
        hold_b = $urandom_range(0, 3);
      end
      q.push_back(model(0, t_a));
      q.push_back(model(1, t_b));
    end
    @(negedge clk);
    #1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Per-line (full DUT) and per-frame (reduced DUT) aggregate counters, taken from DUT outputs.
  bit seg_clean [2];
  int seg_y     [2];
  int cnt_cyc   [2];
  int cnt_act   [2];
  int cnt_hs    [2];
  int cnt_vs    [2];

  function automatic void check_segment(int d);
    int w_cyc, w_act, w_hs, w_vs;
    if (d == 0) begin
      w_cyc = 800;
      w_act = (seg_y[0] < 480) ? 640 : 0;
      w_hs  = 96;
      w_vs  = (seg_y[0] >= 490 && seg_y[0] <= 491) ? 800 : 0;
    end else begin
      w_cyc = B_HT * B_VT;
      w_act = B_HA * B_VA;
      w_hs  = B_HS * B_VT;
      w_vs  = B_VS * B_HT;
    end
    vectors++;
    if (cnt_cyc[d] != w_cyc || cnt_act[d] != w_act || cnt_hs[d] != w_hs || cnt_vs[d] != w_vs) begin
      miscompares++;
      $display("FAIL segment dut%0d y=%0d: got cyc=%0d act=%0d hs=%0d vs=%0d, required cyc=%0d act=%0d hs=%0d vs=%0d",
               d, seg_y[d], cnt_cyc[d], cnt_act[d], cnt_hs[d], cnt_vs[d], w_cyc, w_act, w_hs, w_vs);
    end
  endfunction

  // Monitor: pops each expectation at the falling edge and compares against the matching DUT.
  initial begin
    exp_t e;
    int   ax, ay;
    bit   aact, ahs, avs, arst, sa, start;
    for (int k = 0; k < 2; k++) begin
      seg_clean[k] = 1'b0; seg_y[k] = 0;
      cnt_cyc[k] = 0; cnt_act[k] = 0; cnt_hs[k] = 0; cnt_vs[k] = 0;
    end
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.dut == 0) begin
          ax = int'(cx_a); ay = int'(cy_a); aact = act_a; ahs = hs_a; avs = vs_a; arst = rstn_a; sa = 1'b1;
        end else begin
          ax = int'(cx_b); ay = int'(cy_b); aact = act_b; ahs = hs_b; avs = vs_b; arst = rstn_b; sa = 1'b0;
        end
        vectors++;
        if (ax !== e.x || ay !== e.y || aact !== e.act || ahs !== e.hs || avs !== e.vs) begin
          miscompares++;
          $display("FAIL scoreboard dut%0d t=%0d rstn=%0b: got x=%0d y=%0d act=%0b hs=%0b vs=%0b, required x=%0d y=%0d act=%0b hs=%0b vs=%0b",
                   e.dut, e.t, arst, ax, ay, aact, ahs, avs, e.x, e.y, e.act, e.hs, e.vs);
        end
        if (!arst) begin
          seg_clean[e.dut] = 1'b0;
        end else begin
          start = (e.dut == 0) ? (ax == 0) : (ax == 0 && ay == 0);
          if (start) begin
            if (seg_clean[e.dut]) check_segment(e.dut);
            seg_clean[e.dut] = 1'b1;
            seg_y[e.dut]     = ay;
            cnt_cyc[e.dut] = 0; cnt_act[e.dut] = 0; cnt_hs[e.dut] = 0; cnt_vs[e.dut] = 0;
          end
          cnt_cyc[e.dut]++;
          if (aact)      cnt_act[e.dut]++;
          if (ahs == sa) cnt_hs[e.dut]++;
          if (avs == sa) cnt_vs[e.dut]++;
        end
      end
    end
  end

endmodule
